// File: rtl/dma_desc_sched.sv
// ---------------------------------------------------------------------------
// dma_desc_sched
//
// Round-robin descriptor scheduler that lets PORTS independent descriptor
// sources share a single DMA engine. Each accepted request is registered into
// a one-entry output stage and tagged with {source port, source tag}. A global
// counter bounds the number of descriptors in flight to OP_LIMIT. Completion
// status coming back from the engine is decoded by the port field of its tag
// and pulsed on that port's status output one cycle later.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   enable                     allow new grants (status routing is unaffected)
//   s_axis_req_*               per-port request inputs, port i at slice i;
//                              s_axis_req_ready is one-hot or zero
//   m_axis_desc_*              registered descriptor to the DMA engine;
//                              tag = {port, per-port tag}
//   s_axis_desc_status_*       completion strobe from the engine (no stall)
//   m_axis_status_*            routed per-port completion, one-cycle pulse
//   outstanding                descriptors accepted but not yet completed
//   status_underflow           sticky: a completion arrived with nothing
//                              outstanding; cleared only by reset
//
// Optional feature (macro DMA_DESC_SCHED_STATS_EN):
//   stat_issue_count           per-port 32-bit count of accepted descriptors
//   stat_error_count           per-port 32-bit count of routed completions
//                              carrying a nonzero error code
// ---------------------------------------------------------------------------
module dma_desc_sched #(
    parameter int PORTS          = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int LEN_WIDTH      = 16,
    parameter int TAG_WIDTH      = 8,
    parameter int OP_LIMIT       = 16,
    parameter int PORT_SEL_WIDTH = $clog2(PORTS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,

    input  logic [PORTS*ADDR_WIDTH-1:0]         s_axis_req_addr,
    input  logic [PORTS*LEN_WIDTH-1:0]          s_axis_req_len,
    input  logic [PORTS*TAG_WIDTH-1:0]          s_axis_req_tag,
    input  logic [PORTS-1:0]                    s_axis_req_valid,
    output logic [PORTS-1:0]                    s_axis_req_ready,

    output logic [ADDR_WIDTH-1:0]               m_axis_desc_addr,
    output logic [LEN_WIDTH-1:0]                m_axis_desc_len,
    output logic [PORT_SEL_WIDTH+TAG_WIDTH-1:0] m_axis_desc_tag,
    output logic                                m_axis_desc_valid,
    input  logic                                m_axis_desc_ready,

    input  logic [PORT_SEL_WIDTH+TAG_WIDTH-1:0] s_axis_desc_status_tag,
    input  logic [3:0]                          s_axis_desc_status_error,
    input  logic                                s_axis_desc_status_valid,

    output logic [PORTS*TAG_WIDTH-1:0]          m_axis_status_tag,
    output logic [PORTS*4-1:0]                  m_axis_status_error,
    output logic [PORTS-1:0]                    m_axis_status_valid,

    output logic [$clog2(OP_LIMIT+1)-1:0]       outstanding,
    output logic                                status_underflow
`ifdef DMA_DESC_SCHED_STATS_EN
    ,
    output logic [PORTS*32-1:0]                 stat_issue_count,
    output logic [PORTS*32-1:0]                 stat_error_count
`endif
);

    localparam int CNT_WIDTH = $clog2(OP_LIMIT+1);
    localparam int DTAG_WIDTH = PORT_SEL_WIDTH + TAG_WIDTH;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [PORT_SEL_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]     desc_addr_q, desc_addr_d;
    logic [LEN_WIDTH-1:0]      desc_len_q, desc_len_d;
    logic [DTAG_WIDTH-1:0]     desc_tag_q, desc_tag_d;
    logic                      desc_valid_q, desc_valid_d;
    logic [PORTS*TAG_WIDTH-1:0] st_tag_q, st_tag_d;
    logic [PORTS*4-1:0]        st_err_q, st_err_d;
    logic [PORTS-1:0]          st_valid_q, st_valid_d;
    logic [CNT_WIDTH-1:0]      outstanding_q, outstanding_d;
    logic                      underflow_q, underflow_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                      can_issue;
    logic                      grant_found;
    logic [PORT_SEL_WIDTH-1:0] grant_idx;
    logic [PORT_SEL_WIDTH-1:0] cand_idx;
    logic                      accept;
    logic [PORT_SEL_WIDTH-1:0] st_port;
    logic [TAG_WIDTH-1:0]      st_tag_in;
    logic                      st_port_ok;
    logic                      st_hit;
    logic                      st_dec;

    // The output stage can take a new descriptor when it is empty or being
    // drained this cycle, and only while the in-flight budget has room.
    assign can_issue = enable
                     && (!desc_valid_q || m_axis_desc_ready)
                     && (outstanding_q < CNT_WIDTH'(OP_LIMIT));

    // Rotating priority search: first valid port at or after ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 0; k < PORTS; k++) begin
            cand_idx = PORT_SEL_WIDTH'((int'(ptr_q) + k) % PORTS);
            if (!grant_found && s_axis_req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Ready is held low during reset so no source sees a phantom accept.
    always_comb begin
        s_axis_req_ready = '0;
        if (!rst && can_issue && grant_found) begin
            s_axis_req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept = !rst && can_issue && grant_found;

    // Status decode: port index sits above the per-port tag. With a
    // non-power-of-two PORTS the port field can name a nonexistent port.
    assign st_port    = s_axis_desc_status_tag[TAG_WIDTH +: PORT_SEL_WIDTH];
    assign st_tag_in  = s_axis_desc_status_tag[TAG_WIDTH-1:0];
    assign st_port_ok = ({1'b0, st_port} < (PORT_SEL_WIDTH+1)'(PORTS));
    assign st_hit     = s_axis_desc_status_valid && st_port_ok;
    assign st_dec     = s_axis_desc_status_valid && (outstanding_q != '0);

    // Descriptor output stage and round-robin pointer.
    always_comb begin
        ptr_d        = ptr_q;
        desc_addr_d  = desc_addr_q;
        desc_len_d   = desc_len_q;
        desc_tag_d   = desc_tag_q;
        desc_valid_d = desc_valid_q;
        if (accept) begin
            desc_addr_d  = s_axis_req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            desc_len_d   = s_axis_req_len[grant_idx*LEN_WIDTH +: LEN_WIDTH];
            desc_tag_d   = {grant_idx, s_axis_req_tag[grant_idx*TAG_WIDTH +: TAG_WIDTH]};
            desc_valid_d = 1'b1;
            if (grant_idx == PORT_SEL_WIDTH'(PORTS-1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + PORT_SEL_WIDTH'(1);
            end
        end else if (m_axis_desc_ready) begin
            desc_valid_d = 1'b0;
        end
    end

    // Status routing: only the addressed port's slice is updated; the valid
    // vector is rebuilt every cycle so each completion is a single pulse.
    always_comb begin
        st_valid_d = '0;
        st_tag_d   = st_tag_q;
        st_err_d   = st_err_q;
        if (st_hit) begin
            st_valid_d[st_port]               = 1'b1;
            st_tag_d[st_port*TAG_WIDTH +: TAG_WIDTH] = st_tag_in;
            st_err_d[st_port*4 +: 4]          = s_axis_desc_status_error;
        end
    end

    // In-flight accounting. A completion with nothing outstanding is flagged
    // and ignored for counting; accept and a real completion cancel out.
    always_comb begin
        outstanding_d = outstanding_q;
        underflow_d   = underflow_q;
        if (s_axis_desc_status_valid && (outstanding_q == '0)) begin
            underflow_d = 1'b1;
        end
        if (accept && !st_dec) begin
            outstanding_d = outstanding_q + CNT_WIDTH'(1);
        end else if (!accept && st_dec) begin
            outstanding_d = outstanding_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q         <= '0;
            desc_addr_q   <= '0;
            desc_len_q    <= '0;
            desc_tag_q    <= '0;
            desc_valid_q  <= 1'b0;
            st_tag_q      <= '0;
            st_err_q      <= '0;
            st_valid_q    <= '0;
            outstanding_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            desc_addr_q   <= desc_addr_d;
            desc_len_q    <= desc_len_d;
            desc_tag_q    <= desc_tag_d;
            desc_valid_q  <= desc_valid_d;
            st_tag_q      <= st_tag_d;
            st_err_q      <= st_err_d;
            st_valid_q    <= st_valid_d;
            outstanding_q <= outstanding_d;
            underflow_q   <= underflow_d;
        end
    end

    assign m_axis_desc_addr    = desc_addr_q;
    assign m_axis_desc_len     = desc_len_q;
    assign m_axis_desc_tag     = desc_tag_q;
    assign m_axis_desc_valid   = desc_valid_q;
    assign m_axis_status_tag   = st_tag_q;
    assign m_axis_status_error = st_err_q;
    assign m_axis_status_valid = st_valid_q;
    assign outstanding         = outstanding_q;
    assign status_underflow    = underflow_q;

`ifdef DMA_DESC_SCHED_STATS_EN
    // Per-port statistics; counters wrap naturally at 2^32.
    logic [PORTS*32-1:0] issue_cnt_q, issue_cnt_d;
    logic [PORTS*32-1:0] error_cnt_q, error_cnt_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        error_cnt_d = error_cnt_q;
        if (accept) begin
            issue_cnt_d[grant_idx*32 +: 32] = issue_cnt_q[grant_idx*32 +: 32] + 32'd1;
        end
        if (st_hit && (s_axis_desc_status_error != 4'd0)) begin
            error_cnt_d[st_port*32 +: 32] = error_cnt_q[st_port*32 +: 32] + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt_q <= '0;
            error_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            error_cnt_q <= error_cnt_d;
        end
    end

    assign stat_issue_count = issue_cnt_q;
    assign stat_error_count = error_cnt_q;
`endif

endmodule

// File: tb/tb_dma_desc_sched.sv
// ---------------------------------------------------------------------------
// tb_dma_desc_sched
//
// Directed bench for dma_desc_sched with PORTS=4, OP_LIMIT=4, 32-bit
// addresses. Inputs change 1 time unit after the rising edge; outputs are
// examined a little later in the same cycle, away from the edge.
// ---------------------------------------------------------------------------
module tb_dma_desc_sched;

   localparam int PORTS    = 4;
   localparam int AW       = 32;
   localparam int LW       = 16;
   localparam int TW       = 8;
   localparam int OP_LIMIT = 4;

   logic                clk;
   logic                rst;
   logic                enable;
   logic [PORTS*AW-1:0] reqAddr;
   logic [PORTS*LW-1:0] reqLen;
   logic [PORTS*TW-1:0] reqTag;
   logic [PORTS-1:0]    reqValid;
   logic [PORTS-1:0]    reqReady;
   logic [AW-1:0]       descAddr;
   logic [LW-1:0]       descLen;
   logic [9:0]          descTag;
   logic                descValid;
   logic                descReady;
   logic [9:0]          stTag;
   logic [3:0]          stErr;
   logic                stValid;
   logic [PORTS*TW-1:0] mStTag;
   logic [PORTS*4-1:0]  mStErr;
   logic [PORTS-1:0]    mStValid;
   logic [2:0]          outstanding;
   logic                underflow;
`ifdef DMA_DESC_SCHED_STATS_EN
   logic [PORTS*32-1:0] statIssue;
   logic [PORTS*32-1:0] statError;
`endif

   int checkCount = 0;
   int errorCount = 0;

   dma_desc_sched #(
      .PORTS(PORTS), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
      .TAG_WIDTH(TW), .OP_LIMIT(OP_LIMIT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .s_axis_req_addr(reqAddr),
      .s_axis_req_len(reqLen),
      .s_axis_req_tag(reqTag),
      .s_axis_req_valid(reqValid),
      .s_axis_req_ready(reqReady),
      .m_axis_desc_addr(descAddr),
      .m_axis_desc_len(descLen),
      .m_axis_desc_tag(descTag),
      .m_axis_desc_valid(descValid),
      .m_axis_desc_ready(descReady),
      .s_axis_desc_status_tag(stTag),
      .s_axis_desc_status_error(stErr),
      .s_axis_desc_status_valid(stValid),
      .m_axis_status_tag(mStTag),
      .m_axis_status_error(mStErr),
      .m_axis_status_valid(mStValid),
      .outstanding(outstanding),
      .status_underflow(underflow)
`ifdef DMA_DESC_SCHED_STATS_EN
      ,
      .stat_issue_count(statIssue),
      .stat_error_count(statError)
`endif
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its hand-derived expectation.
   task automatic checkOutput(input string name, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, observed, expected);
      end
   endtask

   // Drive the per-cycle control inputs.
   task automatic applyStimulus(input logic [3:0] valid, input logic dReady,
                                input logic en, input logic sValid,
                                input logic [9:0] sTag, input logic [3:0] sErr);
      reqValid  = valid;
      descReady = dReady;
      enable    = en;
      stValid   = sValid;
      stTag     = sTag;
      stErr     = sErr;
   endtask

   // Advance to just after the next rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after an input change.
   task automatic settle;
      #2;
   endtask

   // Expected {port, tag} for each source; source i uses tag 0x10+i.
   logic [9:0] expDescTag [4] = '{10'h010, 10'h111, 10'h212, 10'h313};
   logic [31:0] expAddr   [4] = '{32'hA000_0000, 32'hA000_0100, 32'hA000_0200, 32'hA000_0300};
   logic [9:0] drainTag   [3] = '{10'h111, 10'h313, 10'h010};
   logic [3:0] drainPulse [3] = '{4'b0010, 4'b1000, 4'b0001};

   initial begin
      reqAddr = {32'hA000_0300, 32'hA000_0200, 32'hA000_0100, 32'hA000_0000};
      reqLen  = {16'h0043, 16'h0042, 16'h0041, 16'h0040};
      reqTag  = {8'h13, 8'h12, 8'h11, 8'h10};
      rst = 1'b1;
      applyStimulus(4'hF, 1'b1, 1'b1, 1'b0, 10'h0, 4'h0);

      // Reset state, with requests already pending.
      tick;
      settle;
      checkOutput("rst_ready", 64'(reqReady), 64'h0);
      checkOutput("rst_desc_valid", 64'(descValid), 64'h0);
      checkOutput("rst_desc_tag", 64'(descTag), 64'h0);
      checkOutput("rst_desc_addr", 64'(descAddr), 64'h0);
      checkOutput("rst_status_valid", 64'(mStValid), 64'h0);
      checkOutput("rst_outstanding", 64'(outstanding), 64'h0);
      checkOutput("rst_underflow", 64'(underflow), 64'h0);

      // Round robin from port 0, one accept per cycle, until the limit.
      rst = 1'b0;
      settle;
      checkOutput("rr_ready0", 64'(reqReady), 64'h1);
      for (int k = 0; k < 4; k++) begin
         tick;
         settle;
         checkOutput("rr_desc_valid", 64'(descValid), 64'h1);
         checkOutput("rr_desc_tag", 64'(descTag), 64'(expDescTag[k]));
         checkOutput("rr_desc_addr", 64'(descAddr), 64'(expAddr[k]));
         checkOutput("rr_desc_len", 64'(descLen), 64'(16'h0040 + 16'(k)));
         checkOutput("rr_outstanding", 64'(outstanding), 64'(k + 1));
         if (k < 3) checkOutput("rr_ready_next", 64'(reqReady), 64'(4'b0001 << (k + 1)));
      end
      checkOutput("limit_ready", 64'(reqReady), 64'h0);

      // Descriptor drains, no new accept while at the limit.
      tick;
      settle;
      checkOutput("limit_drained", 64'(descValid), 64'h0);
      checkOutput("limit_ready_hold", 64'(reqReady), 64'h0);
      checkOutput("limit_count", 64'(outstanding), 64'h4);

      // A completion frees a slot only from the next cycle.
      applyStimulus(4'hF, 1'b1, 1'b1, 1'b1, 10'h010, 4'h0);
      settle;
      checkOutput("limit_same_cycle", 64'(reqReady), 64'h0);
      tick;
      applyStimulus(4'hF, 1'b1, 1'b1, 1'b0, 10'h0, 4'h0);
      settle;
      checkOutput("limit_freed_count", 64'(outstanding), 64'h3);
      checkOutput("limit_freed_ready", 64'(reqReady), 64'h1);
      checkOutput("limit_st_pulse", 64'(mStValid), 64'h1);
      checkOutput("limit_st_tag", 64'(mStTag[7:0]), 64'h10);
      tick;
      settle;
      checkOutput("wrap_desc_tag", 64'(descTag), 64'h010);
      checkOutput("wrap_count", 64'(outstanding), 64'h4);
      checkOutput("wrap_pulse_gone", 64'(mStValid), 64'h0);

      // Routed status to port 2 with error 3.
      applyStimulus(4'h0, 1'b1, 1'b1, 1'b1, 10'h25A, 4'h3);
      tick;
      settle;
      checkOutput("st2_valid", 64'(mStValid), 64'h4);
      checkOutput("st2_tag", 64'(mStTag[23:16]), 64'h5A);
      checkOutput("st2_err", 64'(mStErr[11:8]), 64'h3);
      checkOutput("st2_count", 64'(outstanding), 64'h3);

      // Back-to-back completions, one per cycle.
      for (int k = 0; k < 3; k++) begin
         applyStimulus(4'h0, 1'b1, 1'b1, 1'b1, drainTag[k], 4'h0);
         tick;
         settle;
         checkOutput("b2b_pulse", 64'(mStValid), 64'(drainPulse[k]));
         checkOutput("b2b_count", 64'(outstanding), 64'(2 - k));
      end
      applyStimulus(4'h0, 1'b1, 1'b1, 1'b0, 10'h0, 4'h0);
      tick;
      settle;
      checkOutput("b2b_idle", 64'(mStValid), 64'h0);
      checkOutput("pre_underflow", 64'(underflow), 64'h0);

      // Completion with nothing outstanding.
      applyStimulus(4'h0, 1'b1, 1'b1, 1'b1, 10'h122, 4'h0);
      tick;
      applyStimulus(4'h0, 1'b1, 1'b1, 1'b0, 10'h0, 4'h0);
      settle;
      checkOutput("underflow_set", 64'(underflow), 64'h1);
      checkOutput("underflow_count", 64'(outstanding), 64'h0);
      tick;
      settle;
      checkOutput("underflow_sticky", 64'(underflow), 64'h1);

      // Pointer is 1: port 1 alone, then ports 1 and 3 with pointer at 2.
      applyStimulus(4'b0010, 1'b1, 1'b1, 1'b0, 10'h0, 4'h0);
      settle;
      checkOutput("p1_ready", 64'(reqReady), 64'h2);
      tick;
      applyStimulus(4'b1010, 1'b1, 1'b1, 1'b0, 10'h0, 4'h0);
      settle;
      checkOutput("p1_tag", 64'(descTag), 64'h111);
      checkOutput("ptr2_ready", 64'(reqReady), 64'h8);
      tick;
      settle;
      checkOutput("ptr2_tag", 64'(descTag), 64'h313);
      checkOutput("ptr2_count", 64'(outstanding), 64'h2);
      checkOutput("ptr0_ready", 64'(reqReady), 64'h2);
      applyStimulus(4'b1000, 1'b1, 1'b1, 1'b0, 10'h0, 4'h0);
      settle;
      checkOutput("drop_skip_ready", 64'(reqReady), 64'h8);
      tick;
      settle;
      checkOutput("drop_count", 64'(outstanding), 64'h3);

      // Engine stalls for 5 cycles with a descriptor pending.
      applyStimulus(4'b0001, 1'b0, 1'b1, 1'b0, 10'h0, 4'h0);
      for (int k = 0; k < 5; k++) begin
         settle;
         checkOutput("stall_ready", 64'(reqReady), 64'h0);
         checkOutput("stall_valid", 64'(descValid), 64'h1);
         checkOutput("stall_tag", 64'(descTag), 64'h313);
         tick;
      end
      applyStimulus(4'b0001, 1'b1, 1'b1, 1'b0, 10'h0, 4'h0);
      settle;
      checkOutput("release_addr", 64'(descAddr), 64'hA000_0300);
      checkOutput("release_len", 64'(descLen), 64'h0043);
      checkOutput("release_ready", 64'(reqReady), 64'h1);
      tick;
      settle;
      checkOutput("release_tag", 64'(descTag), 64'h010);
      checkOutput("release_count", 64'(outstanding), 64'h4);

      // Bring count to 2, then accept and complete in the same cycle.
      applyStimulus(4'h0, 1'b1, 1'b1, 1'b1, 10'h313, 4'h0);
      tick;
      applyStimulus(4'h0, 1'b1, 1'b1, 1'b1, 10'h111, 4'h0);
      tick;
      applyStimulus(4'b0001, 1'b1, 1'b1, 1'b1, 10'h010, 4'h0);
      settle;
      checkOutput("simul_pre_count", 64'(outstanding), 64'h2);
      checkOutput("simul_ready", 64'(reqReady), 64'h1);
      tick;
      applyStimulus(4'h0, 1'b1, 1'b1, 1'b0, 10'h0, 4'h0);
      settle;
      checkOutput("simul_count", 64'(outstanding), 64'h2);
      checkOutput("simul_pulse", 64'(mStValid), 64'h1);

      // Enable low blocks grants.
      applyStimulus(4'hF, 1'b1, 1'b0, 1'b0, 10'h0, 4'h0);
      settle;
      checkOutput("enable_low_ready", 64'(reqReady), 64'h0);

      // Reset in the middle of a burst, then a late completion.
      applyStimulus(4'hF, 1'b1, 1'b1, 1'b0, 10'h0, 4'h0);
      tick;
      tick;
      settle;
      checkOutput("burst_valid", 64'(descValid), 64'h1);
      rst = 1'b1;
      #1;
      checkOutput("midrst_valid", 64'(descValid), 64'h0);
      checkOutput("midrst_count", 64'(outstanding), 64'h0);
      checkOutput("midrst_ready", 64'(reqReady), 64'h0);
      checkOutput("midrst_underflow", 64'(underflow), 64'h0);
      tick;
      rst = 1'b0;
      applyStimulus(4'h0, 1'b1, 1'b1, 1'b1, 10'h212, 4'h0);
      tick;
      applyStimulus(4'h0, 1'b1, 1'b1, 1'b0, 10'h0, 4'h0);
      settle;
      checkOutput("late_underflow", 64'(underflow), 64'h1);
      checkOutput("late_count", 64'(outstanding), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/dma_desc_sched.md
# dma_desc_sched

Round-robin descriptor scheduler that shares one PCIe DMA engine (read or write side of the DMA bench core) between `PORTS` independent descriptor sources. It arbitrates requests, tags each issued descriptor with the source port index, enforces a global outstanding-operation limit, and routes completion status back to the originating port. It sits between the benchmark request generators and the DMA engine descriptor/status interfaces.

## Interface
- `PORTS`, 4: number of requesters, 2..16
- `ADDR_WIDTH`, 64: DMA address width
- `LEN_WIDTH`, 16: transfer length width
- `TAG_WIDTH`, 8: per-port tag width
- `OP_LIMIT`, 16: maximum descriptors in flight, 1..256
- `PORT_SEL_WIDTH`, `$clog2(PORTS)`: derived, do not override

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock
- `rst` in 1: asynchronous active-high reset
- `enable` in 1: issue enable; low blocks new grants, status still routed
- `s_axis_req_addr` in `PORTS*ADDR_WIDTH`: per-port address, port i at slice i
- `s_axis_req_len` in `PORTS*LEN_WIDTH`: per-port length
- `s_axis_req_tag` in `PORTS*TAG_WIDTH`: per-port tag
- `s_axis_req_valid` in `PORTS`: per-port request valid
- `s_axis_req_ready` out `PORTS`: per-port accept, at most one bit high
- `m_axis_desc_addr` out `ADDR_WIDTH`: descriptor address
- `m_axis_desc_len` out `LEN_WIDTH`: descriptor length
- `m_axis_desc_tag` out `PORT_SEL_WIDTH+TAG_WIDTH`: `{port, tag}`
- `m_axis_desc_valid` out 1 / `m_axis_desc_ready` in 1: descriptor handshake
- `s_axis_desc_status_tag` in `PORT_SEL_WIDTH+TAG_WIDTH`: completed tag
- `s_axis_desc_status_error` in 4: completion error code
- `s_axis_desc_status_valid` in 1: status strobe, no backpressure
- `m_axis_status_tag` out `PORTS*TAG_WIDTH`, `m_axis_status_error` out `PORTS*4`, `m_axis_status_valid` out `PORTS`: routed status
- `outstanding` out `$clog2(OP_LIMIT+1)`: descriptors accepted but not completed
- `status_underflow` out 1: sticky, status received with `outstanding==0`

## Operation
- `can_issue = enable && (!m_axis_desc_valid || m_axis_desc_ready) && outstanding < OP_LIMIT`.
- Arbiter: combinational search of `s_axis_req_valid` starting at pointer `ptr`, wrapping; the first valid port i gets `s_axis_req_ready[i]=can_issue`. Ready never depends on other ports' ready.
- On accept of port i: output register loads addr/len/`{i,tag}`, `m_axis_desc_valid<=1`, `ptr<=(i+1) mod PORTS`, `outstanding+=1`.
- Output register holds its contents stable while `valid && !ready`; it clears valid when drained with no new accept.
- Status: the port is the upper `PORT_SEL_WIDTH` bits of the tag. Registered one cycle later on `m_axis_status_*[port]`, a single-cycle valid pulse. Port index ≥ PORTS: no output pulse, counter still decrements.
- Status decrements `outstanding`. Simultaneous accept and status: the count is unchanged. Status at 0: the count stays 0 and `status_underflow<=1`, cleared only by reset.
- Deasserting `enable` does not cancel a descriptor already in the output register.

## Timing
- Reset values: all `m_axis_*_valid` 0, data/tag outputs 0, `ptr` 0, `outstanding` 0, `status_underflow` 0, `s_axis_req_ready` 0 while `rst` high.
- Request → `m_axis_desc_valid`: 1 cycle. Sustained throughput of 1 descriptor/cycle with ready held high.
- Status in → routed status: 1 cycle. Back-to-back statuses are supported every cycle.
- Limit: the accept that makes `outstanding==OP_LIMIT` is the last one until a status arrives. The status cycle frees the slot for the next cycle, not the same cycle.
- Reset asserted mid-operation: state clears immediately, and in-flight completions arriving later count as underflow.

## Configuration
- `DMA_DESC_SCHED_STATS_EN` defined: adds output `stat_issue_count` (`PORTS*32`), per-port count of accepted descriptors that wraps at 2^32 and resets to 0. It also adds output `stat_error_count` (`PORTS*32`), incremented on routed status with nonzero error.
- Undefined: these ports and their counters do not exist, and all other behaviour is identical.

## Test plan
- All 4 ports valid continuously, ready=1: grants in order 0,1,2,3,0… with one descriptor per cycle, tags `{i,tag_i}`.
- Ports 1 and 3 valid, `ptr=2`: port 3 is granted first, then 1. A port dropping valid is skipped the same cycle.
- `OP_LIMIT=4`, ready=1, no status: exactly 4 accepts, then all ready low and `outstanding=4`. One status makes ready high the next cycle.
- `m_axis_desc_ready=0` for 5 cycles with a descriptor pending: outputs stay stable, no further ready, data matches on release.
- Status tag `{2,0x5A}` error 3 → `m_axis_status_valid=4'b0100`, port 2 tag 0x5A, error 3, one cycle later. Status with `outstanding=0` → `status_underflow=1`, count stays 0.
- Accept and status in the same cycle at `outstanding=2` → count remains 2. Assert `rst` mid-burst → all valids 0 immediately, `outstanding=0`.
